// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Bundles the signals between the hazard/stall controller and the
//            pipeline, the mul/div unit and the data-memory port.
// Modports : master - the hazard controller. It reads the hazard flags and
//                     handshakes, and drives the stall, bubble, mul/div,
//                     dmem request and counter outputs.
//            slave  - the pipeline/environment side (mirror image).
// Params   : CNT_W - performance counter width.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // Hazard sources
  logic             ID_lu_rs1_i;
  logic             ID_lu_rs2_i;
  logic             EXE_redirect_i;
  logic             IF_imem_wait_i;
  logic             trap_i;
  // Mul/div handshake
  logic             EXE_muldiv_i;
  logic             muldiv_done_i;
  logic             muldiv_start_o;
  logic             muldiv_kill_o;
  // Data-memory handshake
  logic             MEM_mem_req_i;
  logic             dmem_req_o;
  logic             dmem_gnt_i;
  logic             dmem_rvalid_i;
  // Per-stage controls
  logic             IF_stall_o;
  logic             ID_stall_o;
  logic             EXE_stall_o;
  logic             MEM_stall_o;
  logic             IF_ID_bubble_o;
  logic             ID_EXE_bubble_o;
  logic             EXE_MEM_bubble_o;
  logic             MEM_WB_bubble_o;
  // Performance counters
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] lu_cnt_o;

  modport master (
    input  ID_lu_rs1_i, ID_lu_rs2_i, EXE_redirect_i, IF_imem_wait_i, trap_i,
    input  EXE_muldiv_i, muldiv_done_i,
    output muldiv_start_o, muldiv_kill_o,
    input  MEM_mem_req_i, dmem_gnt_i, dmem_rvalid_i,
    output dmem_req_o,
    output IF_stall_o, ID_stall_o, EXE_stall_o, MEM_stall_o,
    output IF_ID_bubble_o, ID_EXE_bubble_o, EXE_MEM_bubble_o, MEM_WB_bubble_o,
    output stall_cnt_o, lu_cnt_o
  );

  modport slave (
    output ID_lu_rs1_i, ID_lu_rs2_i, EXE_redirect_i, IF_imem_wait_i, trap_i,
    output EXE_muldiv_i, muldiv_done_i,
    input  muldiv_start_o, muldiv_kill_o,
    output MEM_mem_req_i, dmem_gnt_i, dmem_rvalid_i,
    input  dmem_req_o,
    input  IF_stall_o, ID_stall_o, EXE_stall_o, MEM_stall_o,
    input  IF_ID_bubble_o, ID_EXE_bubble_o, EXE_MEM_bubble_o, MEM_WB_bubble_o,
    input  stall_cnt_o, lu_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard and stall controller for the 5-stage pipeline
//            (IF, ID, EXE, MEM, WB). It sequences the multi-cycle mul/div
//            unit and the data-memory req/gnt/rvalid handshake. It merges
//            load-use, redirect, fetch-wait and trap events into per-stage
//            stall and bubble controls, and keeps two performance counters.
// Ports    : clk_i  - core clock, rising edge
//            rst_ni - asynchronous active-low reset
//            bus    - hazard_ctrl_if.master (hazard flags, mul/div and dmem
//                     handshakes, stall/bubble outputs, counters)
// Params   : CNT_W  - performance counter width (counters wrap)
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  hazard_ctrl_if.master bus
);

  // --------------------------------------------------------------------------
  // State encodings
  // --------------------------------------------------------------------------
  localparam logic [1:0] X_IDLE  = 2'd0;
  localparam logic [1:0] X_BUSY  = 2'd1;
  localparam logic [1:0] X_DONE  = 2'd2;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_WAIT  = 2'd1;
  localparam logic [1:0] M_DRAIN = 2'd2;

  logic [1:0]       r_x_state;
  logic [1:0]       r_m_state;
  logic [1:0]       w_x_next;
  logic [1:0]       w_m_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_lu_cnt;

  logic w_lu;
  logic w_trap;
  logic w_x_idle;
  logic w_x_busy;
  logic w_m_idle;
  logic w_m_wait;
  logic w_m_drain;
  logic w_dmem_req;
  logic w_start;
  logic w_mdu_stall;
  logic w_mem_stall;
  logic w_exe_stall;
  logic w_id_stall;
  logic w_if_stall;

  // --------------------------------------------------------------------------
  // State decode
  // --------------------------------------------------------------------------
  assign w_lu      = bus.ID_lu_rs1_i | bus.ID_lu_rs2_i;
  assign w_trap    = bus.trap_i;
  assign w_x_idle  = (r_x_state == X_IDLE);
  assign w_x_busy  = (r_x_state == X_BUSY);
  assign w_m_idle  = (r_m_state == M_IDLE);
  assign w_m_wait  = (r_m_state == M_WAIT);
  assign w_m_drain = (r_m_state == M_DRAIN);

  // --------------------------------------------------------------------------
  // Stall network
  // --------------------------------------------------------------------------
  // A trapping instruction in MEM must not issue a new access.
  assign w_dmem_req = w_m_idle & bus.MEM_mem_req_i & ~w_trap;

  // A trap does not cancel an outstanding access. While one is pending
  // (M_WAIT about to become M_DRAIN, or M_DRAIN itself) MEM keeps
  // stalling until the response arrives. The M_WAIT term therefore covers
  // the "entering drain" case without any trap qualification.
  assign w_mem_stall = (w_m_idle & w_dmem_req)
                     | ((w_m_wait | w_m_drain) & ~bus.dmem_rvalid_i);

  assign w_start     = w_x_idle & bus.EXE_muldiv_i;

  // Mul/div and the front-end hazards are flushed by a trap. Only the
  // memory drain may still hold the pipeline.
  assign w_mdu_stall = ~w_trap & (w_start | (w_x_busy & ~bus.muldiv_done_i));
  assign w_exe_stall = w_mem_stall | w_mdu_stall;
  assign w_id_stall  = w_exe_stall | (~w_trap & w_lu);
  assign w_if_stall  = w_id_stall  | (~w_trap & bus.IF_imem_wait_i);

  assign bus.MEM_stall_o = w_mem_stall;
  assign bus.EXE_stall_o = w_exe_stall;
  assign bus.ID_stall_o  = w_id_stall;
  assign bus.IF_stall_o  = w_if_stall;

  // --------------------------------------------------------------------------
  // Bubble network
  // --------------------------------------------------------------------------
  assign bus.MEM_WB_bubble_o  = w_mem_stall | w_trap;
  assign bus.EXE_MEM_bubble_o = (w_exe_stall & ~w_mem_stall) | w_trap;
  assign bus.ID_EXE_bubble_o  = (~w_exe_stall & (w_lu | bus.EXE_redirect_i))
                              | w_trap;
  // If a wrong-path fetch must go, or IF has nothing valid to hand over
  // while ID advances, IF/ID gets a NOP.
  assign bus.IF_ID_bubble_o   = (~w_exe_stall & bus.EXE_redirect_i)
                              | (bus.IF_imem_wait_i & ~w_id_stall)
                              | w_trap;

  // --------------------------------------------------------------------------
  // Mul/div and memory handshake outputs
  // --------------------------------------------------------------------------
  assign bus.muldiv_start_o = w_start;
  assign bus.muldiv_kill_o  = w_trap & (w_x_busy | w_start);
  assign bus.dmem_req_o     = w_dmem_req;

  // --------------------------------------------------------------------------
  // Mul/div FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_x_next = r_x_state;
    if (w_trap) begin
      w_x_next = X_IDLE;
    end else begin
      case (r_x_state)
        X_IDLE: if (bus.EXE_muldiv_i)  w_x_next = X_BUSY;
        X_BUSY: if (bus.muldiv_done_i) w_x_next = X_DONE;
        // Hold the finished result until the op actually leaves EXE.
        // Otherwise a MEM stall would make the same op restart.
        X_DONE: if (!w_exe_stall)      w_x_next = X_IDLE;
        default:                       w_x_next = X_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Memory FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_m_next = r_m_state;
    case (r_m_state)
      // rvalid means nothing here; a same-cycle gnt+rvalid still waits.
      M_IDLE: if (w_dmem_req && bus.dmem_gnt_i) w_m_next = M_WAIT;
      M_WAIT: begin
        // A response that arrives in the trap cycle completes the access.
        // Draining would then wait for a second response that never
        // comes.
        if (bus.dmem_rvalid_i)  w_m_next = M_IDLE;
        else if (w_trap)        w_m_next = M_DRAIN;
      end
      M_DRAIN: if (bus.dmem_rvalid_i) w_m_next = M_IDLE;
      default:                        w_m_next = M_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x_state <= X_IDLE;
      r_m_state <= M_IDLE;
    end else begin
      r_x_state <= w_x_next;
      r_m_state <= w_m_next;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters (wrap modulo 2^CNT_W)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_lu_cnt    <= '0;
    end else begin
      if (w_if_stall)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_lu && !w_exe_stall)
        r_lu_cnt <= r_lu_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.lu_cnt_o    = r_lu_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. It runs directed scenarios,
//            then constrained-random traffic with a mid-run reset. All
//            outputs are compared every cycle against a transaction-level
//            model of the mul/div unit, the memory port and the counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int CW  = 4;
  localparam int MOD = 1 << CW;

  // Input vector bit masks
  localparam logic [9:0] RS1  = 10'h001;
  localparam logic [9:0] RS2  = 10'h002;
  localparam logic [9:0] RDR  = 10'h004;
  localparam logic [9:0] MUL  = 10'h008;
  localparam logic [9:0] DONE = 10'h010;
  localparam logic [9:0] MREQ = 10'h020;
  localparam logic [9:0] GNT  = 10'h040;
  localparam logic [9:0] RV   = 10'h080;
  localparam logic [9:0] IMW  = 10'h100;
  localparam logic [9:0] TRAP = 10'h200;
  localparam logic [9:0] NONE = 10'h000;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, kept in transaction terms
  bit mdu_running;   // op issued, result not yet delivered
  bit mdu_holding;   // result delivered, op has not left EXE yet
  bit mem_live;      // access granted, response outstanding
  bit mem_orphan;    // trapped access whose response must be dropped
  int exp_stall_cnt;
  int exp_lu_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdu_running   = 1'b0;
    mdu_holding   = 1'b0;
    mem_live      = 1'b0;
    mem_orphan    = 1'b0;
    exp_stall_cnt = 0;
    exp_lu_cnt    = 0;
  endtask

  task automatic drive(input logic [9:0] v);
    bus.ID_lu_rs1_i    = v[0];
    bus.ID_lu_rs2_i    = v[1];
    bus.EXE_redirect_i = v[2];
    bus.EXE_muldiv_i   = v[3];
    bus.muldiv_done_i  = v[4];
    bus.MEM_mem_req_i  = v[5];
    bus.dmem_gnt_i     = v[6];
    bus.dmem_rvalid_i  = v[7];
    bus.IF_imem_wait_i = v[8];
    bus.trap_i         = v[9];
  endtask

  // Applies one cycle of inputs, checks every output mid-cycle, then
  // advances the model to what the next clock edge should produce.
  task automatic run_cycle(input logic [9:0] v);
    bit lu, rdr, mul, done, mreq, gnt, rv, imw, trap;
    bit e_req, e_start, e_kill, e_mem, e_mdu, e_exe, e_id, e_if;
    @(posedge clk_i);
    #1;
    drive(v);
    #4;
    lu   = v[0] | v[1];
    rdr  = v[2]; mul = v[3]; done = v[4]; mreq = v[5];
    gnt  = v[6]; rv  = v[7]; imw  = v[8]; trap = v[9];

    // Memory: a new access only when nothing is outstanding. A pending
    // (live or orphaned) access holds MEM until its response arrives.
    e_req = !mem_live && !mem_orphan && mreq && !trap;
    e_mem = e_req || ((mem_live || mem_orphan) && !rv);
    // Mul/div: an op arriving with the unit free is started and held.
    // A running op holds EXE until its done pulse.
    e_start = !mdu_running && !mdu_holding && mul;
    e_kill  = trap && (mdu_running || e_start);
    e_mdu   = !trap && (e_start || (mdu_running && !done));
    e_exe   = e_mem || e_mdu;
    e_id    = e_exe || (!trap && lu);
    e_if    = e_id  || (!trap && imw);

    chk("dmem_req",     32'(bus.dmem_req_o),       32'(e_req));
    chk("muldiv_start", 32'(bus.muldiv_start_o),   32'(e_start));
    chk("muldiv_kill",  32'(bus.muldiv_kill_o),    32'(e_kill));
    chk("MEM_stall",    32'(bus.MEM_stall_o),      32'(e_mem));
    chk("EXE_stall",    32'(bus.EXE_stall_o),      32'(e_exe));
    chk("ID_stall",     32'(bus.ID_stall_o),       32'(e_id));
    chk("IF_stall",     32'(bus.IF_stall_o),       32'(e_if));
    chk("MEM_WB_bub",   32'(bus.MEM_WB_bubble_o),  32'(e_mem || trap));
    chk("EXE_MEM_bub",  32'(bus.EXE_MEM_bubble_o), 32'((e_exe && !e_mem) || trap));
    chk("ID_EXE_bub",   32'(bus.ID_EXE_bubble_o),  32'((!e_exe && (lu || rdr)) || trap));
    chk("IF_ID_bub",    32'(bus.IF_ID_bubble_o),
        32'((!e_exe && rdr) || (imw && !e_id) || trap));
    chk("stall_cnt",    32'(bus.stall_cnt_o),      32'(exp_stall_cnt));
    chk("lu_cnt",       32'(bus.lu_cnt_o),         32'(exp_lu_cnt));

    // Advance the model
    if (trap) begin
      mdu_running = 1'b0;
      mdu_holding = 1'b0;
    end else if (e_start) begin
      mdu_running = 1'b1;
    end else if (mdu_running && done) begin
      mdu_running = 1'b0;
      mdu_holding = 1'b1;
    end else if (mdu_holding && !e_exe) begin
      mdu_holding = 1'b0;
    end

    if (mem_live) begin
      if (rv)        mem_live = 1'b0;
      else if (trap) begin mem_live = 1'b0; mem_orphan = 1'b1; end
    end else if (mem_orphan) begin
      if (rv)        mem_orphan = 1'b0;
    end else if (e_req && gnt) begin
      mem_live = 1'b1;
    end

    if (e_if)          exp_stall_cnt = (exp_stall_cnt + 1) % MOD;
    if (lu && !e_exe)  exp_lu_cnt    = (exp_lu_cnt + 1) % MOD;
  endtask

  // Asserts reset in mid-cycle and checks that everything returns to idle
  // immediately, without waiting for a clock edge.
  task automatic reset_check(input string tag);
    drive(NONE);
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk({tag, "_stall_cnt"}, 32'(bus.stall_cnt_o), 32'(0));
    chk({tag, "_lu_cnt"},    32'(bus.lu_cnt_o),    32'(0));
    chk({tag, "_stalls"},
        32'({bus.IF_stall_o, bus.ID_stall_o, bus.EXE_stall_o, bus.MEM_stall_o}), 32'(0));
    chk({tag, "_bubbles"},
        32'({bus.IF_ID_bubble_o, bus.ID_EXE_bubble_o,
             bus.EXE_MEM_bubble_o, bus.MEM_WB_bubble_o}), 32'(0));
    chk({tag, "_hs"},
        32'({bus.dmem_req_o, bus.muldiv_start_o, bus.muldiv_kill_o}), 32'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  initial begin
    logic [9:0] v;
    drive(NONE);
    rst_ni = 1'b0;
    #2;
    reset_check("reset");

    // Load-use on rs1 for one cycle
    run_cycle(RS1);
    run_cycle(NONE);
    // Mul/div, done after 4 cycles; op lingers in EXE one more cycle
    repeat (4) run_cycle(MUL);
    run_cycle(MUL | DONE);
    run_cycle(MUL);
    run_cycle(NONE);
    // Done arrives while MEM is still waiting for its response
    run_cycle(MREQ | GNT | MUL);
    run_cycle(MUL);
    run_cycle(MUL | DONE);
    run_cycle(MUL);
    run_cycle(MUL | RV);
    run_cycle(NONE);
    // Memory: grant after 2 cycles, response 3 cycles later
    run_cycle(MREQ);
    run_cycle(MREQ);
    run_cycle(MREQ | GNT);
    run_cycle(MREQ);
    run_cycle(MREQ);
    run_cycle(MREQ | RV);
    run_cycle(NONE);
    // Trap while the memory waits and the mul/div unit is busy
    run_cycle(MREQ | GNT | MUL);
    run_cycle(MUL);
    run_cycle(MUL | TRAP);
    run_cycle(NONE);
    run_cycle(NONE);
    run_cycle(RV);
    run_cycle(NONE);
    // Redirect with fetch wait
    run_cycle(RDR | IMW);
    // Same-cycle grant and response
    run_cycle(MREQ | GNT | RV);
    run_cycle(RV);
    run_cycle(NONE);
    // Stall counter wrap: 16 fetch-wait cycles
    repeat (MOD) run_cycle(IMW);
    run_cycle(RS2 | RDR);

    // Constrained-random traffic with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(posedge clk_i);
        #2;
        reset_check("midreset");
      end
      v = NONE;
      v[0] = pct(15);
      v[1] = pct(15);
      v[2] = pct(15);
      v[3] = pct(35);
      v[4] = pct(30);
      v[5] = pct(45);
      v[6] = pct(40);
      v[7] = pct(35);
      v[8] = pct(20);
      v[9] = pct(4);
      run_cycle(v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core (IF, ID, EXE, MEM, WB). It consumes the load-use indications from the rs1/rs2 bypass units, sequences the multi-cycle mul/div unit and the data-memory request/grant/response handshake, and derives per-stage stall and bubble controls for the pipeline registers. It also provides two free-running performance counters.

## Interface
Parameters:
- CNT_W, 32: performance counter width.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- ID_lu_rs1_i, ID_lu_rs2_i  in  1 each  load-use hazard flags from the rs1/rs2 bypass units.
- EXE_redirect_i  in  1  EXE holds a valid taken branch or jump.
- EXE_muldiv_i  in  1  EXE holds a valid multi-cycle mul/div op.
- muldiv_done_i  in  1  mul/div result valid (single-cycle pulse).
- muldiv_start_o  out  1  mul/div start pulse.
- muldiv_kill_o  out  1  abort the in-flight mul/div.
- MEM_mem_req_i  in  1  MEM holds a valid load/store.
- dmem_req_o  out  1  data-memory request.
- dmem_gnt_i  in  1  data-memory grant.
- dmem_rvalid_i  in  1  data-memory response valid.
- IF_imem_wait_i  in  1  fetch data not yet available.
- trap_i  in  1  exception/interrupt commit: flush the pipeline.
- IF_stall_o, ID_stall_o, EXE_stall_o, MEM_stall_o  out  1 each  hold the stage's pipeline register.
- IF_ID_bubble_o, ID_EXE_bubble_o, EXE_MEM_bubble_o, MEM_WB_bubble_o  out  1 each  load a NOP (valid=0) into the named pipeline register.
- stall_cnt_o  out  CNT_W  cycles with IF_stall_o=1.
- lu_cnt_o  out  CNT_W  load-use bubbles inserted.

## Operation
Combined load-use flag: lu = ID_lu_rs1_i | ID_lu_rs2_i.

Mul/div FSM (X_IDLE, X_BUSY, X_DONE):
- X_IDLE: if EXE_muldiv_i, assert muldiv_start_o and go to X_BUSY. The start cycle stalls EXE.
- X_BUSY: stall EXE until muldiv_done_i. On done, go to X_DONE; EXE is not stalled by the mul/div unit that cycle.
- X_DONE: no mul/div stall. Go to X_IDLE on the first cycle with EXE_stall_o=0. This prevents a restart while MEM is stalled.

Memory FSM (M_IDLE, M_WAIT, M_DRAIN):
- M_IDLE: dmem_req_o = MEM_mem_req_i & ~trap_i, and MEM stalls while it is asserted. On dmem_gnt_i, go to M_WAIT.
- M_WAIT: dmem_req_o=0. Stall MEM until dmem_rvalid_i. On rvalid, go to M_IDLE with no stall that cycle. A load therefore takes at least 2 cycles.
- M_DRAIN: entered from M_WAIT on trap_i. MEM_stall_o=1 until dmem_rvalid_i; the response is discarded. Then go to M_IDLE.

Stall equations:
- MEM_stall_o = ((M_IDLE & dmem_req_o) | (M_WAIT & ~dmem_rvalid_i) | (M_DRAIN & ~dmem_rvalid_i)).
- EXE_stall_o = MEM_stall_o | (X_IDLE & EXE_muldiv_i) | (X_BUSY & ~muldiv_done_i).
- ID_stall_o = EXE_stall_o | lu.
- IF_stall_o = ID_stall_o | IF_imem_wait_i.
- On trap_i, all stalls are 0, except MEM/EXE/ID/IF stall = 1 when the memory FSM is in M_DRAIN or entering it.

Bubble equations:
- MEM_WB_bubble_o = MEM_stall_o | trap_i.
- EXE_MEM_bubble_o = (EXE_stall_o & ~MEM_stall_o) | trap_i.
- ID_EXE_bubble_o = (~EXE_stall_o & (lu | EXE_redirect_i)) | trap_i.
- IF_ID_bubble_o = (~EXE_stall_o & EXE_redirect_i) | (IF_imem_wait_i & ~ID_stall_o) | trap_i.

Trap handling:
- trap_i forces the mul/div FSM to X_IDLE; muldiv_kill_o = trap_i & (X_BUSY | start this cycle).
- trap_i has priority over all other events in the same cycle.

Counters:
- stall_cnt_o increments when IF_stall_o=1; lu_cnt_o increments when lu & ~EXE_stall_o.
- Both wrap modulo 2^CNT_W.

## Timing
- Reset (asynchronous): FSMs go to X_IDLE and M_IDLE, counters go to 0.
- All outputs are combinational from state and inputs. With inputs at 0 after reset, every stall, bubble, request, start and kill output is 0.
- FSM transitions are registered, so a new state takes effect one cycle after the triggering input.
- Load-use inserts exactly one bubble per hazard when EXE advances; lu is recomputed by the bypass units the next cycle.
- Simultaneous events:
  - muldiv_done_i with MEM_stall_o: EXE stays stalled and the FSM enters X_DONE (no restart).
  - dmem_gnt_i and dmem_rvalid_i on the same cycle: go to M_WAIT (rvalid is only meaningful in M_WAIT/M_DRAIN).
- Reset asserted mid-operation: immediate return to idle. External units are reset by the same rst_ni.

## Test plan
- Load-use: EXE load writes x5 and ID reads x5 (ID_lu_rs1_i=1 for 1 cycle) -> ID_stall_o=IF_stall_o=1 and ID_EXE_bubble_o=1 for exactly that cycle; lu_cnt_o=1; stall_cnt_o=1.
- Mul/div: EXE_muldiv_i=1 with done after 4 cycles -> muldiv_start_o pulses once; EXE_stall_o=1 for 4 cycles; EXE_MEM_bubble_o=1 for those 4 cycles; no second start.
- Done during a memory stall: muldiv_done_i coincides with MEM in M_WAIT for 2 more cycles -> X_DONE held, EXE_stall_o stays 1 until rvalid, muldiv_start_o never re-asserts.
- Memory: MEM_mem_req_i with gnt after 2 cycles and rvalid 3 cycles later -> dmem_req_o=1 for 3 cycles, MEM_stall_o=1 for 5 cycles, MEM_WB_bubble_o=1 for 5 cycles.
- Trap in M_WAIT with mul/div busy -> muldiv_kill_o=1, all four bubbles=1 on the trap cycle, FSM in M_DRAIN with all stalls=1 until rvalid, then all stalls=0.
- Redirect with imem_wait: EXE_redirect_i=1 and IF_imem_wait_i=1, no stalls -> IF_ID_bubble_o=1, ID_EXE_bubble_o=1, IF_stall_o=1, ID_stall_o=0. Counter wrap with CNT_W=4: 16 stall cycles -> stall_cnt_o returns to 0.
